// File: rtl/conv_bias_act_pkg.sv
// Shared constants for the conv bias/activation slice: Q1.7 format limits,
// default geometry and the channel-advance helper.
package conv_bias_act_pkg;

  localparam int Q_W        = 8;
  localparam int FRAC_DEF   = 7;
  localparam int Q_MIN      = -128;
  localparam int Q_MAX      = 127;
  localparam int NUM_CH_DEF = 16;
  localparam int ACC_W_DEF  = 20;
  localparam int IDX_W      = 16;

  // Channel for the next beat: a flagged beat restarts the pixel at 0,
  // otherwise step and wrap at the last channel.
  function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] ch,
                                               input logic             first,
                                               input int               num_ch);
    if (first || (ch >= IDX_W'(num_ch - 1))) begin
      return '0;
    end
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/conv_bias_act_if.sv
// Accumulator-in / activation-out stream bundle. Both sides use valid/ready:
// a transfer happens on a rising edge where valid && ready; while valid is
// high and ready low the sender holds its payload unchanged.
interface conv_bias_act_if
  import conv_bias_act_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_acc;
  logic                    in_first;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [Q_W-1:0]   out_data;
  logic [IDX_W-1:0]        out_ch;

  modport master (
    output in_valid, in_acc, in_first, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_acc, in_first, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/sat_round_q17.sv
// Combinational Q.14 -> Q1.7 stage: bias add, round-half-up shift, saturate.
// With CONV_BIAS_ACT_RELU_EN defined, negative results become 0 (not a clamp).
module sat_round_q17
  import conv_bias_act_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [Q_W-1:0]   bias,
  output logic signed [Q_W-1:0]   q,
  output logic                    sat
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] QHI  = SW'(Q_MAX);
  localparam logic signed [SW-1:0] QLO  = SW'(Q_MIN);

  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] bias_x;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    acc_x   = acc;
    bias_x  = bias;
    sum     = acc_x + (bias_x <<< FRAC) + HALF;
    shifted = sum >>> FRAC;
    q       = shifted[Q_W-1:0];
    sat     = 1'b0;
    if (shifted > QHI) begin
      q   = Q_W'(Q_MAX);
      sat = 1'b1;
    end
`ifdef CONV_BIAS_ACT_RELU_EN
    else if (shifted[SW-1]) begin
      q = '0;
    end
`else
    else if (shifted < QLO) begin
      q   = Q_W'(Q_MIN);
      sat = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/conv_bias_act.sv
// Two-stage bias + round + saturate (+ optional ReLU via CONV_BIAS_ACT_RELU_EN)
// applied per output channel to a stream of convolution accumulators.
module conv_bias_act
  import conv_bias_act_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_bias_act_if.slave        strm,
  output logic [IDX_W-1:0]      bias_row,
  output logic [IDX_W-1:0]      bias_col,
  input  logic signed [Q_W-1:0] bias_data,
  output logic [IDX_W-1:0]      sat_cnt
);

  logic                    en;
  logic                    accept;
  logic [IDX_W-1:0]        ch;
  logic [IDX_W-1:0]        ch_eff;

  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_acc;
  logic signed [Q_W-1:0]   s1_bias;
  logic [IDX_W-1:0]        s1_ch;

  logic signed [Q_W-1:0]   res;
  logic                    res_sat;

  // One enable stalls the whole pipe, so a blocked output freezes everything.
  assign en            = !strm.out_valid || strm.out_ready;
  assign strm.in_ready = en;
  assign accept        = strm.in_valid && en;
  assign ch_eff        = next_ch(ch, strm.in_first, NUM_CH);
  assign bias_row      = ch_eff;
  assign bias_col      = '0;

  sat_round_q17 #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_sat (
    .acc  (s1_acc),
    .bias (s1_bias),
    .q    (res),
    .sat  (res_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch             <= IDX_W'(NUM_CH - 1);
      s1_valid       <= 1'b0;
      s1_acc         <= '0;
      s1_bias        <= '0;
      s1_ch          <= '0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_ch    <= '0;
      sat_cnt        <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        ch      <= ch_eff;
        s1_acc  <= strm.in_acc;
        s1_bias <= bias_data;
        s1_ch   <= ch_eff;
      end
      strm.out_valid <= s1_valid;
      if (s1_valid) begin
        strm.out_data <= res;
        strm.out_ch   <= s1_ch;
        if (res_sat && (sat_cnt != '1)) begin
          sat_cnt <= sat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/conv_bias_act.md
CONV_BIAS_ACT -- requirements
Module: conv_bias_act

Interface
REQ-001 Parameter NUM_CH, default 16, number of output channels and the bias ROM depth.
REQ-002 Parameter ACC_W, default 20, signed accumulator width in Q.14 scale (Q1.7 x Q1.7 products).
REQ-003 Parameter FRAC, default 7, right-shift from accumulator scale to Q1.7 output scale.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  accumulator beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_acc  input  ACC_W  signed accumulator for the current channel.
REQ-009 in_first  input  1  beat is channel 0 of a new pixel.
REQ-010 bias_row  output  16  bias ROM row select, equal to the current channel counter.
REQ-011 bias_col  output  16  bias ROM column select, constant 0.
REQ-012 bias_data  input  8  signed Q1.7 bias from the combinational bias ROM.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  8  signed Q1.7 activated result.
REQ-016 out_ch  output  16  channel index of out_data.
REQ-017 sat_cnt  output  16  count of saturated results, sticky at 0xFFFF.

Function
REQ-018 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-019 A beat is accepted when in_valid && in_ready.
REQ-020 Channel counter ch SHALL be 0 when the accepted beat has in_first=1; otherwise it SHALL be the previous channel + 1, wrapping from NUM_CH-1 to 0.
REQ-021 Stage 1 (on accept): register in_acc, bias_data (read with bias_row = effective ch), and ch; s1_valid=1. When en=1 and no beat is accepted, s1_valid=0.
REQ-022 Stage 2 (when en): sum = s1_acc + (s1_bias <<< FRAC) + 2^(FRAC-1), in ACC_W+1 bits; q = sum >>> FRAC (arithmetic shift, round-half-up).
REQ-023 Saturate q to [-128, 127]. A clamp SHALL increment sat_cnt once per result when out_valid is loaded.
REQ-024 Register the result into out_data, out_ch and out_valid=s1_valid; latency from accept to out_valid is 2 cycles with no stall.
REQ-025 When en=0, every pipeline register, ch and sat_cnt SHALL hold. out_data SHALL remain stable while out_valid && !out_ready.
REQ-026 Full throughput: 1 beat per cycle while out_ready=1.

Reset
REQ-027 While rst_n=0: out_valid=0, s1_valid=0, out_data=0, out_ch=0, sat_cnt=0, and ch=NUM_CH-1, so the first beat maps to channel 0.
REQ-028 Reset mid-stream discards all in-flight beats. The first beat after release SHALL be channel 0, regardless of in_first.

Configuration
REQ-029 Macro CONV_BIAS_ACT_RELU_EN defined: negative saturated results SHALL become 0, and a ReLU zeroing SHALL NOT count as saturation.
REQ-030 Macro undefined: the output is the signed saturated value, and negative clamps to -128 SHALL count.

Structure
REQ-031 A shared package SHALL hold the Q1.7 width (8), FRAC, the min/max constants (-128, 127) and the default NUM_CH.
REQ-032 Sub-module sat_round_q17 is combinational: shift, round, saturate, sat flag. The bias ROM SHALL be instantiated outside this block.

Verification
REQ-033 Use bias ROM with ch0=-5, ch1=0, ch3=7, ch10=18. in_first=1, acc=0 -> ch0 out_data=0 with RELU_EN, -5 without; out_valid rises 2 cycles after accept.
REQ-034 Stream of 11 beats, first flagged: beat 10 acc=1000 -> out_ch=10, out_data=26.
REQ-035 Rounding on ch1: acc=64 -> 1; acc=63 -> 0.
REQ-036 ch3 acc=100000 -> 127 and sat_cnt=1. Without RELU_EN, acc=-100000 -> -128 and sat_cnt=2.
REQ-037 Hold out_ready=0 for 5 cycles with in_valid=1: in_ready=0 after the pipeline fills, out_data stable, no beats lost or duplicated, channels continue in sequence after release. 17 unflagged beats wrap ch 15 -> 0.
REQ-038 Assert rst_n low with 2 beats in flight: out_valid drops immediately. The next beat after release yields out_ch=0.
